sync_fifo_n: RTL and testbench

SYNC_FIFO_N -- requirements
Module: sync_fifo_n

---
 rtl/sync_fifo_n.sv | 83 ++++++++
 tb/tb_sync_fifo_n.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_n.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers,
// occupancy thresholds and sticky overflow/underflow flags.
module sync_fifo_n #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       wput,
  output logic                       wrdy,
  output logic [DATA_W-1:0]          rdata,
  input  logic                       rget,
  output logic                       rrdy,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       afull,
  output logic                       aempty,
  output logic                       ovf,
  output logic                       udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LVL);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LVL);

  // Handshake: a write is accepted when wput && wrdy, a read when rget && rrdy;
  // wrdy/rrdy depend only on registered pointers, never on wput/rget.

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              full;
  logic              empty;
  logic              do_wr;
  logic              do_rd;

  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign empty = (wptr == rptr);
  assign wrdy  = !full;
  assign rrdy  = !empty;
  assign count = wptr - rptr;
  assign afull  = (count >= AFULL_C);
  assign aempty = (count <= AEMPTY_C);
  assign rdata  = mem[rptr[AW-1:0]];

  assign do_wr = wput && wrdy;
  assign do_rd = rget && rrdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      if (wput && full)
        ovf <= 1'b1;
      if (rget && empty)
        udf <= 1'b1;
      // flush discards any transfer in the same cycle; the error flags survive it
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_wr)
          wptr <= wptr + 1'b1;
        if (do_rd)
          rptr <= rptr + 1'b1;
      end
    end
  end

  // Storage is not reset; a stale entry is never visible because rrdy gates it.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_wr)
      mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: tb/tb_sync_fifo_n.sv
// Bench for sync_fifo_n: vector table, directed corner sequences and random
// traffic, all checked against a queue-based reference model.
module tb_sync_fifo_n;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AFULL  = DEPTH - 2;
  localparam int AEMPTY = 2;
  localparam int PW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic              wput = 1'b0;
  logic              wrdy;
  logic [DATA_W-1:0] rdata;
  logic              rget = 1'b0;
  logic              rrdy;
  logic              flush = 1'b0;
  logic [PW-1:0]     count;
  logic              afull;
  logic              aempty;
  logic              ovf;
  logic              udf;

  int tests_run = 0;
  int tests_failed = 0;

  // clock/reset block
  always #5 clk = ~clk;

  sync_fifo_n #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPTY)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .wput(wput), .wrdy(wrdy),
    .rdata(rdata), .rget(rget), .rrdy(rrdy), .flush(flush), .count(count),
    .afull(afull), .aempty(aempty), .ovf(ovf), .udf(udf)
  );

  // reference model: the FIFO contents as a queue plus the two sticky flags
  logic [DATA_W-1:0] exp_q[$];
  logic              m_ovf = 1'b0;
  logic              m_udf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic f, input logic wp, input logic rg,
                            input logic [DATA_W-1:0] wd);
    int sz;
    sz = exp_q.size();
    if (r) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wp && sz == DEPTH) m_ovf = 1'b1;
      if (rg && sz == 0)     m_udf = 1'b1;
      if (f) exp_q.delete();
      else begin
        if (rg && sz > 0) void'(exp_q.pop_front());
        if (wp && sz < DEPTH) exp_q.push_back(wd);
      end
    end
  endtask

  task automatic check_model();
    int sz;
    sz = exp_q.size();
    check("count",  32'(count),  32'(sz));
    check("wrdy",   32'(wrdy),   32'(sz < DEPTH));
    check("rrdy",   32'(rrdy),   32'(sz > 0));
    check("afull",  32'(afull),  32'(sz >= AFULL));
    check("aempty", 32'(aempty), 32'(sz <= AEMPTY));
    check("ovf",    32'(ovf),    32'(m_ovf));
    check("udf",    32'(udf),    32'(m_udf));
    if (sz > 0) check("rdata", 32'(rdata), 32'(exp_q[0]));
  endtask

  // driver: apply one cycle of inputs, advance model at the edge, compare after it
  task automatic drive(input logic r, input logic f, input logic wp, input logic rg,
                       input logic [DATA_W-1:0] wd);
    rst = r; flush = f; wput = wp; rget = rg; wdata = wd;
    @(posedge clk);
    model_step(r, f, wp, rg, wd);
    #1;
    check_model();
    rst = 1'b0; flush = 1'b0; wput = 1'b0; rget = 1'b0;
  endtask

  typedef struct {
    logic              rst;
    logic              flush;
    logic              wput;
    logic              rget;
    logic [DATA_W-1:0] wdata;
    logic [PW-1:0]     e_count;
    logic              e_rrdy;
    logic [DATA_W-1:0] e_rdata;
    logic              e_ovf;
    logic              e_udf;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // rst flush wput rget wdata | count rrdy rdata ovf udf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 5'd2, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 5'd3, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd2, 1'b1, 8'h22, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 5'd2, 1'b1, 8'h33, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 1'b1, 8'h44, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 5'd1, 1'b1, 8'h55, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h66, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].wput, vecs[i].rget, vecs[i].wdata);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_rrdy", i),  32'(rrdy),  32'(vecs[i].e_rrdy));
      if (vecs[i].e_rrdy) check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
      check($sformatf("vec%0d_ovf", i),   32'(ovf),   32'(vecs[i].e_ovf));
      check($sformatf("vec%0d_udf", i),   32'(udf),   32'(vecs[i].e_udf));
    end

    // fill to full, then one extra write overflows
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
      check("fill_afull", 32'(afull), 32'(i + 1 >= AFULL));
    end
    check("full_wrdy", 32'(wrdy), 32'd0);
    check("full_count", 32'(count), 32'(DEPTH));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE);
    check("ovf_set", 32'(ovf), 32'd1);
    // full with simultaneous read: write still rejected, read accepted
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hEF);
    for (int i = 1; i < DEPTH; i++) begin
      check("drain_order", 32'(rdata), 32'(8'hA0 + i));
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    end
    check("drained_empty", 32'(rrdy), 32'd0);

    // steady state at count 5 across pointer wrap
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h30 + i));
      check("steady_count", 32'(count), 32'd5);
    end
    check("steady_flags", 32'({ovf, udf}), 32'd0);

    // flush at count 7 with a concurrent write
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
    check("pre_flush_count", 32'(count), 32'd7);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h99);
    check("flush_count", 32'(count), 32'd0);
    check("flush_rdy", 32'({wrdy, rrdy}), 32'b10);

    // reset mid-stream at count 9 with ovf set
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < DEPTH - 9; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("pre_rst_count", 32'(count), 32'd9);
    check("pre_rst_ovf", 32'(ovf), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A);
    check("rst_outputs", 32'({wrdy, rrdy, count, afull, aempty, ovf, udf}),
          32'({1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}));

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, f, wp, rg;
      r  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 149) == 0);
      wp = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 35));
      rg = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 35 : 70));
      drive(r, f, wp, rg, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
